// File: rtl/fft8_input_loader.sv
// fft8_input_loader
// Input stage of the 8-point FFT. Serial complex samples arrive in natural
// order and are written bit-reversed into one half of a ping-pong buffer.
// A full half is then drained as eight first-stage butterfly operand sets.
// Each adjacent pair (2m, 2m+1) of the bit-reversed bank is issued twice:
// once with twiddle index 0 (a + W^0*b) and once with index 4 (a - W^0*b).
// One half loads while the other half issues.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   sample handshake; in_data = {real[31:16], imag[15:0]}
//   out_valid/out_ready operand-set handshake toward the butterfly unit
//   out_num1, out_num2  operands a and b (b is multiplied by the twiddle)
//   out_twiddle_index   twiddle ROM index, 0 or 4 in this stage
//   out_last            high on the eighth issue of a frame
module fft8_input_loader #(
   parameter int DATA_W = 32,
   parameter int TW_W   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_num1,
   output logic [DATA_W-1:0] out_num2,
   output logic [TW_W-1:0]   out_twiddle_index,
   output logic              out_last
);

   logic [DATA_W-1:0] mem [2][8];
   logic [1:0]        full;
   logic              wsel;
   logic              rsel;
   logic [2:0]        wcnt;
   logic [2:0]        icnt;
   logic [1:0]        m;
   logic              wr_en;
   logic              rd_en;

   function automatic logic [2:0] bitrev3(input logic [2:0] v);
      return {v[0], v[1], v[2]};
   endfunction

   assign in_ready  = !full[wsel] && !rst;
   assign out_valid = full[rsel];
   assign wr_en     = in_valid && in_ready;
   assign rd_en     = out_valid && out_ready;

   // wr_en needs the write bank empty and rd_en needs the read bank full,
   // so a simultaneous set and clear always land on different bits of full.
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 2'b00;
         wsel <= 1'b0;
         rsel <= 1'b0;
         wcnt <= 3'd0;
         icnt <= 3'd0;
      end else begin
         if (wr_en) begin
            if (wcnt == 3'd7) begin
               full[wsel] <= 1'b1;
               wsel       <= ~wsel;
            end
            wcnt <= wcnt + 3'd1;
         end
         if (rd_en) begin
            if (icnt == 3'd7) begin
               full[rsel] <= 1'b0;
               rsel       <= ~rsel;
            end
            icnt <= icnt + 3'd1;
         end
      end
   end

   // Bank contents are never cleared; the full flags alone decide validity.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wsel][bitrev3(wcnt)] <= in_data;
      end
   end

   assign m                 = icnt[2:1];
   assign out_num1          = mem[rsel][{m, 1'b0}];
   assign out_num2          = mem[rsel][{m, 1'b1}];
   assign out_twiddle_index = icnt[0] ? TW_W'(4) : '0;
   assign out_last          = out_valid && (icnt == 3'd7);

endmodule
